// File: rtl/xgmii_tx_encoder.sv
// rtl/xgmii_tx_encoder.sv - AXI-Stream to XGMII 64-bit TX encoder; FCS append via `XGMII_TX_FCS_EN
module xgmii_tx_encoder #(
  parameter int P_MIN_IFG = 12
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_link_up,
  input  logic [63:0] s_axis_tdata,
  input  logic [7:0]  s_axis_tkeep,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] o_xgmii_txd,
  output logic [7:0]  o_xgmii_txc
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_TERM,
    ST_IFG,
    ST_DROP
  } state_t;

  localparam logic [63:0] IDLE_WORD  = {8{8'h07}};
  localparam logic [63:0] PREAMBLE   = 64'hD5555555555555FB;
  localparam logic [63:0] ERROR_WORD = {8{8'hFE}};
  localparam logic [7:0]  CHAR_TERM  = 8'hFD;

  state_t      state_q, state_d;
  logic [63:0] txd_q, txd_d;
  logic [7:0]  txc_q, txc_d;
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;

  // Bytes in the tlast beat, and total bytes (data plus any FCS) ahead of FD
  logic [3:0]  n_keep;
  logic [3:0]  tot_bytes;
  // Gap bookkeeping: idle bytes already sent after FD, resulting whole idle beats
  logic        enter_gap;
  logic [3:0]  gap_idles;
  logic [3:0]  gap_n;

`ifdef XGMII_TX_FCS_EN
  logic [31:0] crc_q, crc_d;
  logic [31:0] crc_upd;
  logic [31:0] fcs_w;
  logic [31:0] fcs_shift;
  logic [31:0] fcs_hold_q, fcs_hold_d;
  logic [1:0]  spill_q, spill_d;
`endif

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int b = 0; b < 8; b++) c = c + {3'd0, v[b]};
    return c;
  endfunction

  // Whole idle beats still owed so that FD-to-start spacing reaches P_MIN_IFG
  function automatic logic [3:0] gap_beats(input logic [3:0] idles);
    int gap;
    gap = P_MIN_IFG - int'(idles);
    if (gap <= 0) return 4'd0;
    return 4'((gap + 7) / 8);
  endfunction

`ifdef XGMII_TX_FCS_EN
  // Reflected CRC-32 over the enabled lanes of one beat, lane 0 first
  function automatic logic [31:0] crc32_beat(input logic [31:0] crc_in,
                                             input logic [63:0] data,
                                             input logic [7:0]  keep);
    logic [31:0] c;
    c = crc_in;
    for (int b = 0; b < 8; b++) begin
      if (keep[b]) begin
        c = c ^ {24'd0, data[8*b +: 8]};
        for (int j = 0; j < 8; j++) begin
          c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
      end
    end
    return c;
  endfunction

  assign crc_upd   = crc32_beat(crc_q, s_axis_tdata, s_axis_tkeep);
  assign fcs_w     = ~crc_upd;
  assign tot_bytes = popcount8(s_axis_tkeep) + 4'd4;
`else
  assign tot_bytes = popcount8(s_axis_tkeep);
`endif

  assign n_keep        = popcount8(s_axis_tkeep);
  assign gap_n         = gap_beats(gap_idles);
  assign s_axis_tready = (state_q == ST_DATA) || (state_q == ST_DROP);
  assign o_xgmii_txd   = txd_q;
  assign o_xgmii_txc   = txc_q;

  // Next-state and next-output decode
  always_comb begin
    state_d   = state_q;
    txd_d     = IDLE_WORD;
    txc_d     = 8'hFF;
    ifg_cnt_d = ifg_cnt_q;
    enter_gap = 1'b0;
    gap_idles = 4'd0;
`ifdef XGMII_TX_FCS_EN
    crc_d      = crc_q;
    fcs_shift  = '0;
    fcs_hold_d = fcs_hold_q;
    spill_d    = spill_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid && i_link_up) begin
          txd_d   = PREAMBLE;
          txc_d   = 8'h01;
          state_d = ST_DATA;
`ifdef XGMII_TX_FCS_EN
          crc_d   = '1;
`endif
        end
      end

      ST_DATA: begin
        if (!s_axis_tvalid) begin
          // Underrun: poison the frame and swallow the rest of it
          txd_d   = ERROR_WORD;
          txc_d   = 8'hFF;
          state_d = ST_DROP;
        end else if (!s_axis_tlast) begin
          txd_d = s_axis_tdata;
          txc_d = 8'h00;
`ifdef XGMII_TX_FCS_EN
          crc_d = crc_upd;
`endif
        end else begin
`ifdef XGMII_TX_FCS_EN
          crc_d = crc_upd;
`endif
          // Lanes: data, then FCS bytes, then FD, then idle fill
          for (int k = 0; k < 8; k++) begin
            if (k < int'(n_keep)) begin
              txd_d[8*k +: 8] = s_axis_tdata[8*k +: 8];
              txc_d[k]        = 1'b0;
`ifdef XGMII_TX_FCS_EN
            end else if (k < int'(tot_bytes)) begin
              fcs_shift       = fcs_w >> (8 * (k - int'(n_keep)));
              txd_d[8*k +: 8] = fcs_shift[7:0];
              txc_d[k]        = 1'b0;
`endif
            end else if (k == int'(tot_bytes)) begin
              txd_d[8*k +: 8] = CHAR_TERM;
            end
          end
          if (tot_bytes < 4'd8) begin
            enter_gap = 1'b1;
            gap_idles = 4'd7 - tot_bytes;
          end else begin
            state_d = ST_TERM;
`ifdef XGMII_TX_FCS_EN
            spill_d    = 2'(tot_bytes - 4'd8);
            fcs_hold_d = fcs_w >> (32'd8 * (32'd8 - 32'(n_keep)));
`endif
          end
        end
      end

      ST_TERM: begin
`ifdef XGMII_TX_FCS_EN
        // Leftover FCS bytes (possibly none) precede FD in this beat
        for (int k = 0; k < 8; k++) begin
          if (k < int'(spill_q)) begin
            fcs_shift       = fcs_hold_q >> (8 * k);
            txd_d[8*k +: 8] = fcs_shift[7:0];
            txc_d[k]        = 1'b0;
          end else if (k == int'(spill_q)) begin
            txd_d[8*k +: 8] = CHAR_TERM;
          end
        end
        gap_idles = 4'd7 - {2'b00, spill_q};
`else
        txd_d     = {{7{8'h07}}, CHAR_TERM};
        gap_idles = 4'd7;
`endif
        enter_gap = 1'b1;
      end

      ST_IFG: begin
        if (ifg_cnt_q <= 4'd1) begin
          state_d   = ST_IDLE;
          ifg_cnt_d = 4'd0;
        end else begin
          ifg_cnt_d = ifg_cnt_q - 4'd1;
        end
      end

      ST_DROP: begin
        if (s_axis_tvalid && s_axis_tlast) begin
          enter_gap = 1'b1;
          gap_idles = 4'd0;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // A zero-beat gap skips IFG entirely
    if (enter_gap) begin
      if (gap_n == 4'd0) begin
        state_d = ST_IDLE;
      end else begin
        state_d   = ST_IFG;
        ifg_cnt_d = gap_n;
      end
    end
  end

  // State, gap counter and registered XGMII outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      txd_q     <= IDLE_WORD;
      txc_q     <= 8'hFF;
      ifg_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      txd_q     <= txd_d;
      txc_q     <= txc_d;
      ifg_cnt_q <= ifg_cnt_d;
    end
  end

`ifdef XGMII_TX_FCS_EN
  // Running CRC and the FCS bytes held over for a spill beat
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      crc_q      <= '1;
      fcs_hold_q <= '0;
      spill_q    <= 2'd0;
    end else begin
      crc_q      <= crc_d;
      fcs_hold_q <= fcs_hold_d;
      spill_q    <= spill_d;
    end
  end
`endif

endmodule

// File: tb/tb_xgmii_tx_encoder.sv
// tb/tb_xgmii_tx_encoder.sv - directed self-checking bench for xgmii_tx_encoder
module tb_xgmii_tx_encoder;

  localparam logic [63:0] IDLE_W = 64'h0707070707070707;
  localparam logic [63:0] PRE_W  = 64'hD5555555555555FB;
  localparam logic [63:0] ERR_W  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [63:0] TERM_W = 64'h07070707070707FD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up;
  logic [63:0] tdata;
  logic [7:0]  tkeep;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [63:0] txd;
  logic [7:0]  txc;

  int n_cmp = 0;
  int n_mis = 0;

  xgmii_tx_encoder #(.P_MIN_IFG(12)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_link_up     (link_up),
    .s_axis_tdata  (tdata),
    .s_axis_tkeep  (tkeep),
    .s_axis_tvalid (tvalid),
    .s_axis_tlast  (tlast),
    .s_axis_tready (tready),
    .o_xgmii_txd   (txd),
    .o_xgmii_txc   (txc)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] beat(input int b);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(8 * b + k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [63:0] exp_d, input logic [7:0] exp_c);
    chk({tag, "_txd"}, txd, exp_d);
    chk({tag, "_txc"}, {56'd0, txc}, {56'd0, exp_c});
  endtask

  task automatic chk_rdy(input string tag, input logic exp);
    chk({tag, "_tready"}, {63'd0, tready}, {63'd0, exp});
  endtask

`ifdef XGMII_TX_FCS_EN
  function automatic logic [31:0] crc_ref(input int nbytes);
    logic [31:0] c;
    logic [7:0]  by;
    logic        fb;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < nbytes; i++) begin
      by = 8'(i);
      for (int j = 0; j < 8; j++) begin
        fb = c[0] ^ by[j];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB88320;
      end
    end
    return ~c;
  endfunction
`endif

  initial begin
    logic [63:0] w;
    logic [63:0] exp_w;
    link_up = 1'b1;
    tdata   = '0;
    tkeep   = 8'hFF;
    tvalid  = 1'b0;
    tlast   = 1'b0;

    repeat (3) tick();
    chk_out("reset", IDLE_W, 8'hFF);
    chk_rdy("reset", 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();
    chk_out("post_reset_idle", IDLE_W, 8'hFF);

`ifdef XGMII_TX_FCS_EN
    // 60-byte frame 0x00..0x3B, FCS lands in lanes 4..7, then TERM
    tvalid = 1'b1;
    tdata  = beat(0);
    tick();
    chk_out("fcs_pre", PRE_W, 8'h01);
    for (int b = 0; b < 8; b++) begin
      tdata = beat(b);
      tlast = (b == 7);
      tkeep = (b == 7) ? 8'h0F : 8'hFF;
      tick();
      if (b < 7) begin
        chk_out("fcs_data", beat(b), 8'h00);
      end else begin
        w = beat(7);
        exp_w = {crc_ref(60), w[31:0]};
        chk_out("fcs_last", exp_w, 8'h00);
      end
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'hFF;
    tick();
    chk_out("fcs_term", TERM_W, 8'hFF);
    tick();
    chk_out("fcs_gap", IDLE_W, 8'hFF);
    tick();
    chk_out("fcs_idle", IDLE_W, 8'hFF);
`else
    // Frame A: 64 bytes in 8 full beats
    tvalid = 1'b1;
    tdata  = beat(0);
    chk_rdy("a_idle", 1'b0);
    tick();
    chk_out("a_pre", PRE_W, 8'h01);
    chk_rdy("a_pre", 1'b1);
    for (int b = 0; b < 8; b++) begin
      tdata = beat(b);
      tlast = (b == 7);
      tick();
      chk_out("a_data", beat(b), 8'h00);
    end
    tdata = beat(8);
    tlast = 1'b0;
    tick();
    chk_out("a_term", TERM_W, 8'hFF);
    chk_rdy("a_term", 1'b0);
    tick();
    chk_out("a_gap", IDLE_W, 8'hFF);
    tick();
    chk_out("b_pre", PRE_W, 8'h01);

    // Frame B: 61 bytes, last tkeep 0x1F, two idle beats follow
    for (int b = 0; b < 8; b++) begin
      tdata = beat(8 + b);
      tlast = (b == 7);
      tkeep = (b == 7) ? 8'h1F : 8'hFF;
      tick();
      if (b < 7) begin
        chk_out("b_data", beat(8 + b), 8'h00);
      end else begin
        w = beat(15);
        exp_w = {16'h0707, 8'hFD, w[39:0]};
        chk_out("b_last", exp_w, 8'hE0);
      end
    end
    tdata = beat(16);
    tlast = 1'b0;
    tkeep = 8'hFF;
    tick();
    chk_out("b_gap1", IDLE_W, 8'hFF);
    tick();
    chk_out("b_gap2", IDLE_W, 8'hFF);
    tick();
    chk_out("c_pre", PRE_W, 8'h01);

    // Frame C: underrun after 3 beats, remainder dropped
    for (int b = 0; b < 3; b++) begin
      tdata = beat(16 + b);
      tick();
      chk_out("c_data", beat(16 + b), 8'h00);
    end
    tvalid = 1'b0;
    tick();
    chk_out("c_err", ERR_W, 8'hFF);
    tvalid = 1'b1;
    for (int b = 3; b < 8; b++) begin
      tdata = beat(16 + b);
      tlast = (b == 7);
      chk_rdy("c_drop", 1'b1);
      tick();
      chk_out("c_drop", IDLE_W, 8'hFF);
    end

    // Link gating: tvalid held high while link is down
    link_up = 1'b0;
    tlast   = 1'b0;
    tdata   = beat(24);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk_out("link_down", IDLE_W, 8'hFF);
      chk_rdy("link_down", 1'b0);
    end
    link_up = 1'b1;
    tick();
    chk_out("d_pre", PRE_W, 8'h01);
    tick();
    chk_out("d_data0", beat(24), 8'h00);

    // Asynchronous reset in the middle of frame D
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", IDLE_W, 8'hFF);
    chk_rdy("rst_mid", 1'b0);
    tvalid = 1'b0;
    #1;
    rst_n = 1'b1;
    repeat (2) tick();
    chk_out("rst_after", IDLE_W, 8'hFF);

    // Frame E: clean restart, last beat holds a single byte
    tvalid = 1'b1;
    tdata  = beat(32);
    tick();
    chk_out("e_pre", PRE_W, 8'h01);
    tick();
    chk_out("e_data", beat(32), 8'h00);
    tdata = beat(33);
    tkeep = 8'h01;
    tlast = 1'b1;
    tick();
    w = beat(33);
    exp_w = {48'h070707070707, 8'hFD, w[7:0]};
    chk_out("e_last", exp_w, 8'hFE);
    tvalid = 1'b0;
    tlast  = 1'b0;
    tkeep  = 8'hFF;
    tick();
    chk_out("e_gap", IDLE_W, 8'hFF);
    tick();
    chk_out("e_idle", IDLE_W, 8'hFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/xgmii_tx_encoder.md
Name: xgmii_tx_encoder

Overview:
- MAC-side transmitter that drives the XGMII TX input of the 10G PCS/PMA core.
- Converts a 64-bit AXI-Stream frame into an XGMII 64-bit/8-lane character stream. It inserts the preamble/SFD, the terminate character, idle fill and the minimum inter-frame gap, and aborts underrun frames with error characters.
- Runs on the core's XGMII clock (coreclk).

Parameters:
- P_MIN_IFG, 12: minimum inter-frame gap in bytes, counted from the terminate character (exclusive) to the next start. Legal range 8..64.

Ports:
- i_clk, input, 1: XGMII clock; all logic is on its rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_link_up, input, 1: PCS RX link/block sync. When 0, no new frame is started.
- s_axis_tdata, input, 64: frame data; byte 0 = bits 7:0 = first on the wire.
- s_axis_tkeep, input, 8: byte enables. All ones except on the tlast beat; contiguous from lane 0, at least 1 byte.
- s_axis_tvalid, input, 1: beat valid.
- s_axis_tlast, input, 1: last beat of the frame.
- s_axis_tready, output, 1: beat accepted when tvalid & tready.
- o_xgmii_txd, output, 64: XGMII TX data, lane k = bits 8k+7:8k.
- o_xgmii_txc, output, 8: XGMII TX control, bit k set = lane k carries a control character.

Behaviour:
- **Reset:** txd = 0x0707070707070707, txc = 0xFF, tready = 0, state IDLE, IFG counter 0, CRC = 0xFFFFFFFF.
- **Output registers:** txd/txc are registered. tready is decoded from state: 1 in DATA and DROP, 0 otherwise.
- **States:** IDLE, DATA, TERM, IFG, DROP.
- **IDLE:**
  - Outputs idle (0x07 on all lanes, txc = 0xFF).
  - If tvalid & i_link_up, the next cycle outputs preamble txd = 0xD5555555555555FB, txc = 0x01, and the state goes to DATA.
  - Start is always in lane 0.
- **DATA, tvalid & !tlast:** the next cycle outputs tdata with txc = 0x00.
- **DATA, tvalid & tlast with n = popcount(tkeep):**
  - n < 8: lanes 0..n-1 carry data, lane n = 0xFD (ctrl), lanes n+1..7 = 0x07 (ctrl). Go to IFG.
  - n = 8: all 8 lanes carry data. Go to TERM.
- **TERM:** outputs FD in lane 0 and 07 in lanes 1..7, txc = 0xFF. Go to IFG.
- **IFG:**
  - Idle bytes already sent after FD: i = 7-n (n < 8) or 7 (TERM).
  - Inserts ceil(max(0, P_MIN_IFG - i)/8) whole idle beats, then IDLE.
  - A count of 0 goes straight to IDLE; the earliest next preamble is then the cycle after IDLE.
- **Underrun (DATA & !tvalid):**
  - The next cycle outputs an error beat: txd = 0xFEFEFEFEFEFEFEFE, txc = 0xFF. Go to DROP.
  - DROP: tready = 1, outputs idle, discards beats until a tlast handshake, then IFG with i = 0.
  - No terminate character is sent for an aborted frame.
- **i_link_up falling:**
  - Mid-frame has no effect; the frame completes.
  - In IDLE it blocks the start.
- **Async reset mid-frame:** outputs return to idle immediately; any partial frame is lost.
- **Throughput:** back-to-back data beats at 1 beat/cycle. Latency from accepted beat to txd is 1 cycle.
- **Padding:** none. Upstream guarantees at least 60 bytes (FCS option off) or at least 60 bytes before FCS (option on).

Optional Feature:
- Macro XGMII_TX_FCS_EN.
- **Defined:**
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final XOR 0xFFFFFFFF) is computed over all accepted bytes, masked by tkeep.
  - The 4 FCS bytes are appended LS byte first after the last data byte, and FD follows the FCS.
  - n ≤ 3: FCS plus FD fit in the tlast beat.
  - n = 4: FCS fills lanes 4..7, then a TERM beat follows.
  - n ≥ 5: a spill beat carries the remaining n-4 FCS bytes in lanes 0..n-5, FD in lane n-4, and 07 above.
  - The IFG idle count uses the byte position of FD in whichever beat carries it.
  - CRC resets to 0xFFFFFFFF at every preamble. Aborted frames get no FCS.
- **Undefined:** frames are passed through unchanged; no CRC logic is present.

Test Plan:
- **64-byte frame, 8 full beats, P_MIN_IFG = 12:** output is the preamble beat FB..D5/txc 0x01, then 8 data beats with txc 0x00, then a TERM beat FD + 7×07. The next preamble is at least 2 beats after TERM (i = 7, ceil(5/8) = 1 IFG beat, then IDLE).
- **61-byte frame (last tkeep = 0x1F):** last beat lanes 0–4 = data, lane 5 = 0xFD, txc = 0xE0. Then ceil((12-2)/8) = 2 idle beats.
- **Underrun:** tvalid drops after beat 3 of 8. The next output is an all-0xFE beat with txc = 0xFF. Remaining beats are consumed with tready = 1 until tlast and never appear on txd.
- **Link gating:** i_link_up = 0 with tvalid = 1 keeps idle output and tready = 0. Raising i_link_up gives a preamble one cycle later.
- **Reset mid-frame:** asserting i_rst_n = 0 during DATA makes txd = 0x07…07, txc = 0xFF and tready = 0 asynchronously. After release the encoder restarts cleanly on the next frame.
- **XGMII_TX_FCS_EN, standard 60-byte test frame:** the frame is 60 bytes of 0x00..0x3B with last tkeep = 0x0F. FCS occupies lanes 4..7 and equals the reference CRC-32. A TERM beat follows with FD in lane 0.
